mp_add_seq: RTL

Multi-precision add sequencer that streams WIDTH-bit operand words through an internal `full_adder` (WIDTH) instance and chains the carry between words, so operands wider than WIDTH are summed one word per beat, least-significant word first. It sits on both sides of the adder. Upstream it accepts operand beats over a valid/ready handshake and drives the adder's `a`/`b`/`cin`. Downstream it registers the adder's `sum`/`cout` into a one-deep output stage with its own valid/ready handshake.

---
 rtl/mp_add_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mp_add_seq.sv
// -----------------------------------------------------------------------------
// mp_add_seq
//
// Multi-precision add sequencer. Operand words stream in least-significant
// word first. Each word is summed by an internal full_adder, and the carry is
// chained from one word to the next. Every result word is registered into a
// one-deep output stage that has its own valid/ready handshake.
//
// Ports
//   clk, rst_n          : clock (rising edge) and async active-low reset
//   in_valid / in_ready : upstream handshake; a beat is taken on valid&&ready
//   in_a, in_b          : operand words (WIDTH bits)
//   in_cin              : carry-in, used only on a first beat
//   in_first, in_last   : beat is least / most significant word of an op
//   out_valid/out_ready : downstream handshake for the result word
//   out_sum, out_cout   : result word and its carry-out
//   out_last            : copy of in_last for this word
//   out_idx             : word index within the op, saturating at 255
//   err                 : sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------

// Plain WIDTH-bit adder with carry in and out.
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module mp_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_last,
  output logic [7:0]       out_idx,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic             carry_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_last_q;
  logic [7:0]       out_idx_q;
  logic             err_q;

  logic             accept;
  logic             first_beat;
  logic             proto_err;
  logic             adder_cin;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_cout;
  logic [7:0]       idx_d;

  // The output stage can take a new word whenever it is empty or being drained
  // this cycle. Nothing here depends on in_valid.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A beat that arrives in IDLE always starts a new operation, even without
  // in_first. This keeps the block recoverable after a missing first marker.
  assign first_beat = in_first || (state_q == IDLE);

  // Error cases: a first marker inside an open op, or a missing first marker
  // when no op is open.
  assign proto_err = (in_first && (state_q == BUSY)) ||
                     (!in_first && (state_q == IDLE));

  assign adder_cin = first_beat ? in_cin : carry_q;

  assign idx_d = first_beat             ? 8'd0 :
                 (out_idx_q == 8'hFF)   ? 8'hFF :
                                          out_idx_q + 8'd1;

  full_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (in_a),
    .b    (in_b),
    .cin  (adder_cin),
    .sum  (adder_sum),
    .cout (adder_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= adder_sum;
        out_cout_q  <= adder_cout;
        out_last_q  <= in_last;
        out_idx_q   <= idx_d;
        // The final carry leaves only on out_cout; it must not leak into
        // the next operation.
        carry_q     <= in_last ? 1'b0 : adder_cout;
        state_q     <= in_last ? IDLE : BUSY;
        if (proto_err) begin
          err_q <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign err       = err_q;

endmodule
